mem_req_arbiter: RTL and testbench

Arbitrates instruction-side and data-side miss requests from the MMU into the single word-level op stream consumed by the memory controller (op / address / write data in, tx_done / rd_valid / read data out). It holds one outstanding transaction at a time, routes the completion back to the requesting side with its thread tag, and flags requests the memory controller never completes. It sits between `MMU` and `mem_ctrl` inside the AFU.

---
 rtl/mem_pkg.sv | 27 ++
 rtl/rr_arb2.sv | 35 +++
 rtl/mem_req_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_mem_req_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the MMU-to-mem_ctrl request path: memory op encoding,
// arbiter state encoding and default word/tag widths.
package mem_pkg;

  localparam int TRD_WIDTH  = 3;
  localparam int DATA_WIDTH = 32;

  // Op encoding seen by mem_ctrl; MEM_IDLE means "no new op this cycle".
  typedef enum logic [1:0] {
    MEM_IDLE  = 2'b00,
    MEM_READ  = 2'b01,
    MEM_WRITE = 2'b10
  } mem_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_RESP  = 2'b11
  } arb_state_t;

  typedef enum logic {
    SIDE_I = 1'b0,
    SIDE_D = 1'b1
  } side_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant between the instruction and data request sides.
// The grant is combinational; the history bit advances only when a grant is taken.
module rr_arb2
  import mem_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  req_i,
  input  logic  req_d,
  input  logic  update,
  output side_t grant,
  output side_t last_grant
);

  always_comb begin
    grant = SIDE_I;
    if (req_i && req_d) begin
      // Tie: favour whichever side did not win last time.
      grant = (last_grant == SIDE_I) ? SIDE_D : SIDE_I;
    end else if (req_d) begin
      grant = SIDE_D;
    end else begin
      grant = SIDE_I;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= SIDE_I;
    end else if (update) begin
      last_grant <= grant;
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Funnels instruction- and data-side miss requests into mem_ctrl one transaction
// at a time, returns the completion to the requesting side and aborts stuck ops.
module mem_req_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int HOST_ADDR_WIDTH = 64,
  parameter int DATA_WIDTH      = mem_pkg::DATA_WIDTH,
  parameter int TRD_WIDTH       = mem_pkg::TRD_WIDTH,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_req,
  input  logic [ADDR_WIDTH-1:0]      i_addr,
  input  logic [TRD_WIDTH-1:0]       i_trd,
  output logic                       i_ack,
  output logic                       i_rsp_valid,
  output logic [DATA_WIDTH-1:0]      i_rsp_data,
  output logic [TRD_WIDTH-1:0]       i_rsp_trd,
  input  logic                       d_req,
  input  logic                       d_wr,
  input  logic [ADDR_WIDTH-1:0]      d_addr,
  input  logic [DATA_WIDTH-1:0]      d_wr_data,
  input  logic [TRD_WIDTH-1:0]       d_trd,
  output logic                       d_ack,
  output logic                       d_rsp_valid,
  output logic [DATA_WIDTH-1:0]      d_rsp_data,
  output logic [TRD_WIDTH-1:0]       d_rsp_trd,
  input  logic                       mc_ready,
  output mem_op_t                    mc_op,
  output logic [HOST_ADDR_WIDTH-1:0] mc_addr,
  output logic [DATA_WIDTH-1:0]      mc_wr_data,
  input  logic [DATA_WIDTH-1:0]      mc_rd_data,
  input  logic                       mc_rd_valid,
  input  logic                       mc_tx_done,
  output logic                       err_timeout,
  output logic [TRD_WIDTH-1:0]       err_trd
);

  // Handshake: a side raises x_req with its payload and holds both until the
  // one-cycle x_ack pulse; requests are only sampled in IDLE with mc_ready=1.
  // x_rsp_valid is a one-cycle pulse with no back-pressure from the requester.

  localparam int CNT_WIDTH = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  arb_state_t           state;
  side_t                side_q;
  logic                 wr_q;
  logic [TRD_WIDTH-1:0] trd_q;
  logic [CNT_WIDTH-1:0] wait_cnt;

  side_t                     gnt_side;
  side_t                     last_grant;
  logic                      take;
  logic                      gnt_wr;
  logic [TRD_WIDTH-1:0]      gnt_trd;
  logic [HOST_ADDR_WIDTH-1:0] gnt_addr;
  logic [DATA_WIDTH-1:0]     gnt_wdata;
  logic                      done_hit;
  logic                      expired;
  logic [DATA_WIDTH-1:0]     rsp_word;
  logic                      unused_addr_lsbs;

  // Byte-offset bits are dropped: mem_ctrl works on word-aligned addresses.
  assign unused_addr_lsbs = ^{i_addr[1:0], d_addr[1:0], last_grant};

  assign take = (state == ST_IDLE) && mc_ready && (i_req || d_req);

  rr_arb2 u_rr_arb2 (
    .clk        (clk),
    .rst        (rst),
    .req_i      (i_req),
    .req_d      (d_req),
    .update     (take),
    .grant      (gnt_side),
    .last_grant (last_grant)
  );

  always_comb begin
    gnt_wr    = 1'b0;
    gnt_trd   = i_trd;
    gnt_addr  = HOST_ADDR_WIDTH'({i_addr[ADDR_WIDTH-1:2], 2'b00});
    gnt_wdata = '0;
    if (gnt_side == SIDE_D) begin
      gnt_wr    = d_wr;
      gnt_trd   = d_trd;
      gnt_addr  = HOST_ADDR_WIDTH'({d_addr[ADDR_WIDTH-1:2], 2'b00});
      gnt_wdata = d_wr ? d_wr_data : '0;
    end
  end

  // Reads finish on mc_rd_valid only, writes on mc_tx_done only.
  always_comb begin
    done_hit = wr_q ? mc_tx_done : mc_rd_valid;
    expired  = (wait_cnt == CNT_LAST);
    rsp_word = '0;
    if (done_hit && !wr_q) begin
      rsp_word = mc_rd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      side_q      <= SIDE_I;
      wr_q        <= 1'b0;
      trd_q       <= '0;
      wait_cnt    <= '0;
      i_ack       <= 1'b0;
      i_rsp_valid <= 1'b0;
      i_rsp_data  <= '0;
      i_rsp_trd   <= '0;
      d_ack       <= 1'b0;
      d_rsp_valid <= 1'b0;
      d_rsp_data  <= '0;
      d_rsp_trd   <= '0;
      mc_op       <= MEM_IDLE;
      mc_addr     <= '0;
      mc_wr_data  <= '0;
      err_timeout <= 1'b0;
      err_trd     <= '0;
    end else begin
      i_ack       <= 1'b0;
      d_ack       <= 1'b0;
      i_rsp_valid <= 1'b0;
      d_rsp_valid <= 1'b0;
      err_timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (take) begin
            state      <= ST_ISSUE;
            side_q     <= gnt_side;
            wr_q       <= gnt_wr;
            trd_q      <= gnt_trd;
            mc_addr    <= gnt_addr;
            mc_wr_data <= gnt_wdata;
            mc_op      <= gnt_wr ? MEM_WRITE : MEM_READ;
            i_ack      <= (gnt_side == SIDE_I);
            d_ack      <= (gnt_side == SIDE_D);
          end
        end
        ST_ISSUE: begin
          mc_op    <= MEM_IDLE;
          wait_cnt <= '0;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          // A completion arriving on the last counted cycle still wins.
          if (done_hit || expired) begin
            state <= ST_RESP;
            if (side_q == SIDE_D) begin
              d_rsp_valid <= 1'b1;
              d_rsp_data  <= rsp_word;
              d_rsp_trd   <= trd_q;
            end else begin
              i_rsp_valid <= 1'b1;
              i_rsp_data  <= rsp_word;
              i_rsp_trd   <= trd_q;
            end
            if (!done_hit) begin
              err_timeout <= 1'b1;
              err_trd     <= trd_q;
            end
          end else begin
            wait_cnt <= wait_cnt + CNT_WIDTH'(1);
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: responses are scoreboarded against an
// expected queue filled at acknowledge time; cycle-level checks are inline.
module tb_mem_req_arbiter;

  localparam int AW  = 32;
  localparam int HAW = 64;
  localparam int DW  = 32;
  localparam int TW  = 3;
  localparam int TO  = 16;

  logic           clk;
  logic           rst;
  logic           i_req;
  logic [AW-1:0]  i_addr;
  logic [TW-1:0]  i_trd;
  logic           i_ack;
  logic           i_rsp_valid;
  logic [DW-1:0]  i_rsp_data;
  logic [TW-1:0]  i_rsp_trd;
  logic           d_req;
  logic           d_wr;
  logic [AW-1:0]  d_addr;
  logic [DW-1:0]  d_wr_data;
  logic [TW-1:0]  d_trd;
  logic           d_ack;
  logic           d_rsp_valid;
  logic [DW-1:0]  d_rsp_data;
  logic [TW-1:0]  d_rsp_trd;
  logic           mc_ready;
  logic [1:0]     mc_op;
  logic [HAW-1:0] mc_addr;
  logic [DW-1:0]  mc_wr_data;
  logic [DW-1:0]  mc_rd_data;
  logic           mc_rd_valid;
  logic           mc_tx_done;
  logic           err_timeout;
  logic [TW-1:0]  err_trd;

  int total = 0;
  int bad   = 0;

  // Entry layout: {i_valid, d_valid, trd, data, err}
  logic [37:0] exp_q[$];
  logic [37:0] mon_obs;
  logic [37:0] mon_exp;

  mem_req_arbiter #(
    .ADDR_WIDTH      (AW),
    .HOST_ADDR_WIDTH (HAW),
    .DATA_WIDTH      (DW),
    .TRD_WIDTH       (TW),
    .TIMEOUT_CYCLES  (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_req       (i_req),
    .i_addr      (i_addr),
    .i_trd       (i_trd),
    .i_ack       (i_ack),
    .i_rsp_valid (i_rsp_valid),
    .i_rsp_data  (i_rsp_data),
    .i_rsp_trd   (i_rsp_trd),
    .d_req       (d_req),
    .d_wr        (d_wr),
    .d_addr      (d_addr),
    .d_wr_data   (d_wr_data),
    .d_trd       (d_trd),
    .d_ack       (d_ack),
    .d_rsp_valid (d_rsp_valid),
    .d_rsp_data  (d_rsp_data),
    .d_rsp_trd   (d_rsp_trd),
    .mc_ready    (mc_ready),
    .mc_op       (mc_op),
    .mc_addr     (mc_addr),
    .mc_wr_data  (mc_wr_data),
    .mc_rd_data  (mc_rd_data),
    .mc_rd_valid (mc_rd_valid),
    .mc_tx_done  (mc_tx_done),
    .err_timeout (err_timeout),
    .err_trd     (err_trd)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Driver / checker helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [37:0] pack_exp(input bit is_d, input logic [TW-1:0] trd,
                                           input logic [DW-1:0] data, input bit err);
    return {~is_d, is_d, trd, data, err};
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ctl"}, {i_ack, d_ack, i_rsp_valid, d_rsp_valid, err_timeout, mc_op}, '0);
    chk({tag, "_addr"}, mc_addr, '0);
    chk({tag, "_data"}, {i_rsp_data, d_rsp_data}, '0);
    chk({tag, "_misc"}, {mc_wr_data, i_rsp_trd, d_rsp_trd, err_trd}, '0);
  endtask

  // Scoreboard: every response pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && (i_rsp_valid || d_rsp_valid)) begin
      mon_obs = {i_rsp_valid, d_rsp_valid,
                 d_rsp_valid ? d_rsp_trd : i_rsp_trd,
                 d_rsp_valid ? d_rsp_data : i_rsp_data,
                 err_timeout};
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL rsp_unexpected observed=%0h expected=none", mon_obs);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("rsp", {26'd0, mon_obs}, {26'd0, mon_exp});
        if (mon_exp[0]) chk("err_trd", {61'd0, err_trd}, {61'd0, mon_exp[35:33]});
      end
    end
  end

  initial begin
    logic          got;
    logic          flag;
    logic          want_d;
    logic [DW-1:0] rdata;

    rst = 1'b1;
    i_req = 0; i_addr = '0; i_trd = '0;
    d_req = 0; d_wr = 0; d_addr = '0; d_wr_data = '0; d_trd = '0;
    mc_ready = 0; mc_rd_data = '0; mc_rd_valid = 0; mc_tx_done = 0;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Single i-side read, data returned on the third WAIT cycle
    i_req = 1; i_addr = 32'h0000_1006; i_trd = 3'd5; mc_ready = 1;
    tick();
    chk("t1_ack", {i_ack, d_ack}, 2'b10);
    chk("t1_op", mc_op, 2'b01);
    chk("t1_addr", mc_addr, 64'h1004);
    i_req = 0;
    exp_q.push_back(pack_exp(0, 3'd5, 32'hDEAD_BEEF, 0));
    tick();
    chk("t1_op_wait", {mc_op, i_ack}, '0);
    chk("t1_addr_hold", mc_addr, 64'h1004);
    tick();
    tick();
    mc_rd_valid = 1; mc_rd_data = 32'hDEAD_BEEF;
    tick();
    mc_rd_valid = 0;
    chk("t1_rsp_lat", {i_rsp_valid, d_rsp_valid}, 2'b10);
    tick();
    chk("t1_rsp_pulse", i_rsp_valid, 0);

    // d-side write; stray strobes in ISSUE and the read strobe are ignored
    d_req = 1; d_wr = 1; d_addr = 32'h200; d_wr_data = 32'h1234_5678; d_trd = 3'd2;
    tick();
    chk("t2_ack", {i_ack, d_ack}, 2'b01);
    chk("t2_op", mc_op, 2'b10);
    chk("t2_wdata", mc_wr_data, 64'h1234_5678);
    chk("t2_addr", mc_addr, 64'h200);
    d_req = 0; d_wr = 0;
    mc_tx_done = 1;
    exp_q.push_back(pack_exp(1, 3'd2, '0, 0));
    tick();
    chk("t2_issue_strobe_ignored", d_rsp_valid, 0);
    chk("t2_wdata_hold", mc_wr_data, 64'h1234_5678);
    mc_tx_done = 0; mc_rd_valid = 1; mc_rd_data = 32'hFFFF_0000;
    tick();
    chk("t2_rdvalid_ignored", {i_rsp_valid, d_rsp_valid}, 2'b00);
    mc_rd_valid = 0; mc_tx_done = 1;
    tick();
    mc_tx_done = 0;
    chk("t2_rsp_lat", {i_rsp_valid, d_rsp_valid}, 2'b01);
    tick();

    // Both sides held after reset: grants go D, I, D
    rst = 1;
    tick();
    rst = 0;
    i_req = 1; i_addr = 32'h400; i_trd = 3'd1;
    d_req = 1; d_wr = 0; d_addr = 32'h300; d_trd = 3'd3;
    for (int k = 0; k < 3; k++) begin
      want_d = (k != 1);
      got = 0;
      for (int c = 0; c < 8 && !got; c++) begin
        tick();
        if (i_ack || d_ack) got = 1;
      end
      chk("t3_ack_seen", got, 1);
      chk("t3_order", {i_ack, d_ack}, want_d ? 2'b01 : 2'b10);
      rdata = $urandom;
      exp_q.push_back(pack_exp(want_d, want_d ? 3'd3 : 3'd1, rdata, 0));
      if (k == 2) begin
        i_req = 0; d_req = 0;
      end
      tick();
      mc_rd_valid = 1; mc_rd_data = rdata;
      tick();
      mc_rd_valid = 0;
      tick();
    end

    // Timeout with no completion
    i_req = 1; i_addr = 32'h80; i_trd = 3'd6;
    tick();
    chk("t4_ack", i_ack, 1);
    i_req = 0;
    exp_q.push_back(pack_exp(0, 3'd6, '0, 1));
    flag = 0;
    repeat (TO) begin
      tick();
      if (i_rsp_valid || err_timeout) flag = 1;
    end
    chk("t4_no_early_abort", flag, 0);
    tick();
    chk("t4_abort", {err_timeout, i_rsp_valid}, 2'b11);
    chk("t4_abort_data", i_rsp_data, '0);
    tick();
    chk("t4_err_pulse", err_timeout, 0);

    // Normal request after the abort
    d_req = 1; d_addr = 32'h600; d_trd = 3'd0;
    tick();
    chk("t4_next_ack", d_ack, 1);
    d_req = 0;
    exp_q.push_back(pack_exp(1, 3'd0, 32'h0F0F_1234, 0));
    tick();
    mc_rd_valid = 1; mc_rd_data = 32'h0F0F_1234;
    tick();
    mc_rd_valid = 0;
    chk("t4_next_rsp", {err_timeout, d_rsp_valid}, 2'b01);
    tick();

    // Completion on the last WAIT cycle beats the timeout
    i_req = 1; i_addr = 32'h84; i_trd = 3'd2;
    tick();
    chk("t4b_ack", i_ack, 1);
    i_req = 0;
    exp_q.push_back(pack_exp(0, 3'd2, 32'hA5A5_5A5A, 0));
    repeat (TO) tick();
    mc_rd_valid = 1; mc_rd_data = 32'hA5A5_5A5A;
    tick();
    mc_rd_valid = 0;
    chk("t4b_done_beats_timeout", {err_timeout, i_rsp_valid}, 2'b01);
    tick();

    // Reset in WAIT drops the transaction
    d_req = 1; d_addr = 32'h700; d_trd = 3'd4;
    tick();
    chk("t5_ack", d_ack, 1);
    d_req = 0;
    tick();
    rst = 1;
    tick();
    check_reset_outputs("t5_rst");
    rst = 0;
    mc_rd_valid = 1; mc_rd_data = 32'h0000_1234;
    flag = 0;
    repeat (3) begin
      tick();
      if (i_rsp_valid || d_rsp_valid || d_ack || i_ack) flag = 1;
    end
    mc_rd_valid = 0;
    chk("t5_no_stale_rsp", flag, 0);
    i_req = 1; i_addr = 32'h2003; i_trd = 3'd4;
    tick();
    chk("t5_fresh_ack", i_ack, 1);
    chk("t5_fresh_addr", mc_addr, 64'h2000);
    i_req = 0;
    exp_q.push_back(pack_exp(0, 3'd4, 32'hCAFE_F00D, 0));
    tick();
    mc_rd_valid = 1; mc_rd_data = 32'hCAFE_F00D;
    tick();
    mc_rd_valid = 0;
    chk("t5_fresh_rsp", i_rsp_valid, 1);
    tick();

    // mc_ready low holds off the grant; dropping it after grant is harmless
    mc_ready = 0;
    d_req = 1; d_addr = 32'h500; d_trd = 3'd7;
    flag = 0;
    repeat (5) begin
      tick();
      if (d_ack || i_ack || (mc_op != 2'b00)) flag = 1;
    end
    chk("t6_held_off", flag, 0);
    mc_ready = 1;
    tick();
    chk("t6_ack", d_ack, 1);
    chk("t6_op", mc_op, 2'b01);
    d_req = 0; mc_ready = 0;
    exp_q.push_back(pack_exp(1, 3'd7, 32'h0BAD_C0DE, 0));
    tick();
    mc_rd_valid = 1; mc_rd_data = 32'h0BAD_C0DE;
    tick();
    mc_rd_valid = 0;
    chk("t6_rsp", d_rsp_valid, 1);
    tick();
    mc_ready = 1;

    repeat (3) tick();
    chk("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
